// File: rtl/hazard_ctrl.sv
// hazard_ctrl -- pipeline hazard controller for the 5-stage MIPS core.
//
// Generates the hold/bubble/flush controls for PC, IF/ID and ID/EX.
// Three hazard sources are handled, in priority order:
//   - A multi-cycle data-memory access in MEM freezes the whole pipeline.
//   - A load-use dependency inserts a bubble.
//   - A taken branch flushes IF/ID.
// Two saturating counters record how many cycles were spent frozen and
// how many cycles were spent bubbling.
//
// Parameters:
//   MEM_LAT  data-memory access latency in cycles (>=1)
//   CNT_W    width of each statistics counter
//
// Ports:
//   clk_i             clock, rising edge
//   rst_i             asynchronous reset, active low
//   IFID_RegAddrRs_i  rs of the instruction in ID
//   IFID_RegAddrRt_i  rt of the instruction in ID
//   IDEX_MemRead_i    MemRead of the instruction in EX
//   IDEX_RegAddrRt_i  rt (load destination) of the instruction in EX
//   EXMEM_MemRead_i   MemRead of the instruction in MEM
//   EXMEM_MemWrite_i  MemWrite of the instruction in MEM
//   Branch_taken_i    branch resolved taken in ID this cycle
//   PCWrite_o         1 = PC updates
//   IFID_Write_o      1 = IF/ID register loads
//   IFID_Flush_o      1 = IF/ID loads a NOP
//   Bubble_o          1 = ID/EX loads all-zero control fields
//   Stall_o           1 = ID/EX and EX/MEM hold their contents
//   Busy_o            controller is waiting on a memory access
//   FreezeCnt_o       number of cycles with Stall_o=1 (saturating)
//   BubbleCnt_o       number of cycles with Bubble_o=1 (saturating)
module hazard_ctrl #(
  parameter int MEM_LAT = 3,
  parameter int CNT_W   = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       IFID_RegAddrRs_i,
  input  logic [4:0]       IFID_RegAddrRt_i,
  input  logic             IDEX_MemRead_i,
  input  logic [4:0]       IDEX_RegAddrRt_i,
  input  logic             EXMEM_MemRead_i,
  input  logic             EXMEM_MemWrite_i,
  input  logic             Branch_taken_i,
  output logic             PCWrite_o,
  output logic             IFID_Write_o,
  output logic             IFID_Flush_o,
  output logic             Bubble_o,
  output logic             Stall_o,
  output logic             Busy_o,
  output logic [CNT_W-1:0] FreezeCnt_o,
  output logic [CNT_W-1:0] BubbleCnt_o
);

  localparam int                CW       = $clog2(MEM_LAT) + 1;
  localparam logic [CW-1:0]     CNT_LOAD = CW'(MEM_LAT - 1);
  localparam logic [CW-1:0]     CNT_ONE  = CW'(1);
  localparam logic [CNT_W-1:0]  STAT_MAX = '1;
  localparam bit                CAN_FREEZE = (MEM_LAT > 1);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic memop;
  logic freeze;
  logic load_use;

  assign memop = EXMEM_MemRead_i | EXMEM_MemWrite_i;

  // A zero destination never creates a dependency since $zero is constant.
  assign load_use = IDEX_MemRead_i && (IDEX_RegAddrRt_i != 5'd0) &&
                    ((IDEX_RegAddrRt_i == IFID_RegAddrRs_i) ||
                     (IDEX_RegAddrRt_i == IFID_RegAddrRt_i));

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The access is detected in RUN and frozen for MEM_LAT-1 cycles; the final
  // WAIT cycle (cnt==1) is the release cycle where the pipe advances. memop is
  // not looked at in WAIT so a held access cannot retrigger itself.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    freeze       = 1'b0;
    PCWrite_o    = 1'b1;
    IFID_Write_o = 1'b1;
    IFID_Flush_o = 1'b0;
    Bubble_o     = 1'b0;
    Stall_o      = 1'b0;
    Busy_o       = 1'b0;

    unique case (state_q)
      ST_RUN: begin
        if (memop && CAN_FREEZE) begin
          freeze  = 1'b1;
          state_d = ST_WAIT;
          cnt_d   = CNT_LOAD;
        end
      end
      ST_WAIT: begin
        if (cnt_q > CNT_ONE) begin
          freeze = 1'b1;
          cnt_d  = cnt_q - CNT_ONE;
        end else begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    endcase

    // While reset is held the pipeline runs freely regardless of the inputs.
    if (rst_i) begin
      Busy_o = (state_q == ST_WAIT);
      if (freeze) begin
        Stall_o      = 1'b1;
        PCWrite_o    = 1'b0;
        IFID_Write_o = 1'b0;
      end else if (load_use) begin
        Bubble_o     = 1'b1;
        PCWrite_o    = 1'b0;
        IFID_Write_o = 1'b0;
      end else if (Branch_taken_i) begin
        IFID_Flush_o = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      FreezeCnt_o <= '0;
      BubbleCnt_o <= '0;
    end else begin
      if (Stall_o && (FreezeCnt_o != STAT_MAX)) begin
        FreezeCnt_o <= FreezeCnt_o + CNT_W'(1);
      end
      if (Bubble_o && (BubbleCnt_o != STAT_MAX)) begin
        BubbleCnt_o <= BubbleCnt_o + CNT_W'(1);
      end
    end
  end

endmodule
